bitty_alu: RTL and testbench
============================

BITTY_ALU -- requirements
Module: bitty_alu

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width; all arithmetic rules below assume WIDTH=16.
REQ-002 clk  input  1  clock; all registers update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_a  input  WIDTH  operand A.
REQ-005 in_b  input  WIDTH  operand B.
REQ-006 select  input  3  operation code.
REQ-007 en  input  1  capture strobe for the registered result and flags.
REQ-008 alu_out  output  WIDTH  combinational result of the current in_a, in_b and select.
REQ-009 res_q  output  WIDTH  registered result.
REQ-010 flag_z  output  1  registered zero flag.
REQ-011 flag_c  output  1  registered carry/borrow flag.
REQ-012 flag_n  output  1  registered sign flag (MSB of the result).
REQ-013 valid  output  1  high for exactly one cycle after each capture.

Function
REQ-014 alu_out SHALL be purely combinational from in_a, in_b and select, with zero-cycle latency and no dependence on clk, reset or en.
REQ-015 select=0: alu_out SHALL be in_a + in_b modulo 2^16; carry = bit 16 of the 17-bit sum.
REQ-016 select=1: alu_out SHALL be in_a - in_b modulo 2^16; carry = 1 when in_a < in_b unsigned (borrow).
REQ-017 select=2: alu_out SHALL be in_a AND in_b; carry = 0.
REQ-018 select=3: alu_out SHALL be in_a OR in_b; carry = 0.
REQ-019 select=4: alu_out SHALL be in_a XOR in_b; carry = 0.
REQ-020 select=5: alu_out SHALL be in_a shifted left logically by in_b; any in_b >= 16 gives 0; carry = last bit shifted out, or 0 when in_b = 0 or in_b > 16.
REQ-021 select=6: alu_out SHALL be in_a shifted right logically by in_b; any in_b >= 16 gives 0; carry = last bit shifted out, or 0 when in_b = 0 or in_b > 16.
REQ-022 select=7: alu_out SHALL be an unsigned compare: 0 if in_a == in_b, 1 if in_a > in_b, 2 if in_a < in_b; carry = 0.
REQ-023 All operands SHALL be treated as unsigned; no overflow detection or saturation.
REQ-024 On a rising edge with en=1, res_q SHALL load alu_out, flag_c SHALL load the carry defined above, flag_z SHALL load (alu_out == 0), and flag_n SHALL load alu_out[15].
REQ-025 On a rising edge with en=1, valid SHALL be set to 1; on any edge with en=0, valid SHALL be 0 and res_q and the flags SHALL hold.
REQ-026 en held high for consecutive cycles SHALL capture on every cycle and keep valid high on each of those cycles.
REQ-027 Input changes without en SHALL affect only alu_out.

Reset
REQ-028 While reset is asserted, res_q SHALL be 0, flag_z 1, flag_c 0, flag_n 0 and valid 0, immediately and without waiting for clk.
REQ-029 Reset asserted mid-capture SHALL win over en; the first capture after deassertion SHALL occur on the first rising edge with en=1 and reset low.
REQ-030 alu_out SHALL remain combinationally correct during reset.

Verification
REQ-031 in_a=0xFFFF, in_b=0x0001, select=0, en pulse -> alu_out=0x0000; after the edge res_q=0, flag_z=1, flag_c=1, valid=1 for one cycle.
REQ-032 in_a=3, in_b=5, select=1 -> alu_out=0xFFFE; after capture flag_c=1, flag_n=1, flag_z=0.
REQ-033 in_a=0x00F0, in_b=0x0FF0: select 2/3/4 -> 0x00F0 / 0x0FF0 / 0x0F00.
REQ-034 in_a=0x8001: select=5 with in_b=1 -> 0x0002 and carry=1; select=6 with in_b=1 -> 0x4000 and carry=1; in_b=20 -> 0 for both shifts.
REQ-035 select=7 with (5,5), (9,2), (2,9) -> 0, 1, 2.
REQ-036 Capture a nonzero result, then assert reset asynchronously between edges -> res_q=0, flag_z=1 and valid=0 immediately; random sweep of all selects checks alu_out against a reference model.

Source files
------------

// File: rtl/bitty_alu.sv
// Single-cycle 8-op ALU: combinational alu_out plus an en-strobed result/flag
// register with a one-cycle valid pulse per capture.
module bitty_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       select,
  input  logic             en,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] res_q,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             valid
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             c;
    logic             n;
  } res_t;

  logic [WIDTH:0] ext;
  logic           carry;
  res_t           rq;

  // One guard bit carries the arithmetic carry/borrow or the last bit shifted
  // out; oversized shift amounts push everything, guard included, off the end.
  always_comb begin
    ext = '0;
    unique case (select)
      3'd0: ext = {1'b0, in_a} + {1'b0, in_b};
      3'd1: ext = {1'b0, in_a} - {1'b0, in_b};
      3'd2: ext = {1'b0, in_a & in_b};
      3'd3: ext = {1'b0, in_a | in_b};
      3'd4: ext = {1'b0, in_a ^ in_b};
      3'd5: ext = {1'b0, in_a} << in_b;
      3'd6: ext = {in_a, 1'b0} >> in_b;
      3'd7: begin
        if (in_a > in_b)      ext = (WIDTH+1)'(1);
        else if (in_a < in_b) ext = (WIDTH+1)'(2);
        else                  ext = '0;
      end
      default: ext = '0;
    endcase
  end

  always_comb begin
    alu_out = ext[WIDTH-1:0];
    carry   = 1'b0;
    case (select)
      3'd0, 3'd1, 3'd5: begin
        alu_out = ext[WIDTH-1:0];
        carry   = ext[WIDTH];
      end
      3'd6: begin
        alu_out = ext[WIDTH:1];
        carry   = ext[0];
      end
      default: begin
        alu_out = ext[WIDTH-1:0];
        carry   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq    <= '{res: '0, z: 1'b1, c: 1'b0, n: 1'b0};
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en)
        rq <= '{res: alu_out, z: (alu_out == '0), c: carry, n: alu_out[WIDTH-1]};
    end
  end

  assign res_q  = rq.res;
  assign flag_z = rq.z;
  assign flag_c = rq.c;
  assign flag_n = rq.n;

endmodule

// File: tb/tb_bitty_alu.sv
// Directed checks of bitty_alu plus a random sweep against a loop-based model.
module tb_bitty_alu;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_a, in_b;
  logic [2:0]  select;
  logic        en;
  logic [15:0] alu_out, res_q;
  logic        flag_z, flag_c, flag_n, valid;

  int n_cmp = 0;
  int n_bad = 0;

  bitty_alu #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .select(select),
    .en(en), .alu_out(alu_out), .res_q(res_q), .flag_z(flag_z),
    .flag_c(flag_c), .flag_n(flag_n), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, result}, shifts modelled one bit at a time.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] s);
    logic [15:0] v;
    logic        c;
    int          n;
    v = a; c = 1'b0;
    n = (b > 17) ? 17 : int'(b);
    case (s)
      3'd0: return 17'(a) + 17'(b);
      3'd1: return {a < b, 16'(a - b)};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: begin for (int i = 0; i < n; i++) begin c = v[15]; v = v << 1; end return {c, v}; end
      3'd6: begin for (int i = 0; i < n; i++) begin c = v[0];  v = v >> 1; end return {c, v}; end
      default: return (a == b) ? 17'd0 : (a > b) ? 17'd1 : 17'd2;
    endcase
  endfunction

  // Drive operands at the falling edge, capture on the next rising edge.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s,
                      input logic e);
    @(negedge clk);
    in_a = a; in_b = b; select = s; en = e;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [16:0] m;
    reset = 1'b1; in_a = 16'h0; in_b = 16'h0; select = 3'd0; en = 1'b0;
    #1;
    chk("rst_res", res_q, 16'h0);
    chk("rst_flags", {flag_z, flag_c, flag_n, valid}, 4'b1000);
    in_a = 16'h0003; in_b = 16'h0004; #1;
    chk("rst_comb", alu_out, 16'h0007);
    @(negedge clk); reset = 1'b0;

    // Add overflow wraps to zero with carry
    @(negedge clk); in_a = 16'hFFFF; in_b = 16'h0001; select = 3'd0; en = 1'b1; #1;
    chk("add_comb", alu_out, 16'h0000);
    @(posedge clk); #1;
    chk("add_res", res_q, 16'h0000);
    chk("add_flags", {flag_z, flag_c, flag_n, valid}, 4'b1101);
    step(16'h1234, 16'h1111, 3'd0, 1'b0);
    chk("vld_drop", valid, 1'b0);
    chk("hold_res", res_q, 16'h0000);
    chk("hold_comb", alu_out, 16'h2345);

    // Subtract borrow
    step(16'd3, 16'd5, 3'd1, 1'b1);
    chk("sub_res", res_q, 16'hFFFE);
    chk("sub_flags", {flag_z, flag_c, flag_n, valid}, 4'b0111);
    // Back-to-back captures keep valid high
    step(16'd5, 16'd3, 3'd1, 1'b1);
    chk("b2b1", {res_q, flag_c, valid}, {16'h0002, 1'b0, 1'b1});
    step(16'h00F0, 16'h0FF0, 3'd2, 1'b1);
    chk("and_res", res_q, 16'h00F0);
    chk("b2b2_vld", valid, 1'b1);
    @(negedge clk); en = 1'b0;
    select = 3'd3; #1; chk("or", alu_out, 16'h0FF0);
    select = 3'd4; #1; chk("xor", alu_out, 16'h0F00);

    // Shifts: by 1, by 16 (carry is the final bit out), by 20 and by 0
    step(16'h8001, 16'd1, 3'd5, 1'b1);
    chk("shl1", {res_q, flag_c}, {16'h0002, 1'b1});
    step(16'h8001, 16'd1, 3'd6, 1'b1);
    chk("shr1", {res_q, flag_c}, {16'h4000, 1'b1});
    step(16'h8001, 16'd20, 3'd5, 1'b1);
    chk("shl20", {res_q, flag_c, flag_z}, {16'h0000, 1'b0, 1'b1});
    step(16'h8001, 16'd20, 3'd6, 1'b1);
    chk("shr20", {res_q, flag_c, flag_z}, {16'h0000, 1'b0, 1'b1});
    step(16'h0001, 16'd16, 3'd5, 1'b1);
    chk("shl16", {res_q, flag_c}, {16'h0000, 1'b1});
    step(16'h8000, 16'd16, 3'd6, 1'b1);
    chk("shr16", {res_q, flag_c}, {16'h0000, 1'b1});
    step(16'h8001, 16'd0, 3'd5, 1'b1);
    chk("shl0", {res_q, flag_c, flag_n}, {16'h8001, 1'b0, 1'b1});

    // Unsigned compare
    @(negedge clk); en = 1'b0; select = 3'd7;
    in_a = 16'd5; in_b = 16'd5; #1; chk("cmp_eq", alu_out, 16'd0);
    in_a = 16'd9; in_b = 16'd2; #1; chk("cmp_gt", alu_out, 16'd1);
    in_a = 16'd2; in_b = 16'd9; #1; chk("cmp_lt", alu_out, 16'd2);
    in_a = 16'hFFFF; in_b = 16'h0001; #1; chk("cmp_uns", alu_out, 16'd1);

    // Async reset between edges, then reset winning over en
    step(16'h0040, 16'h0002, 3'd0, 1'b1);
    chk("pre_rst", res_q, 16'h0042);
    #2 reset = 1'b1; #1;
    chk("arst_res", res_q, 16'h0000);
    chk("arst_flags", {flag_z, flag_c, flag_n, valid}, 4'b1000);
    chk("arst_comb", alu_out, 16'h0042);
    @(posedge clk); #1;
    chk("rst_en", {res_q, valid}, {16'h0000, 1'b0});
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst", {res_q, valid}, {16'h0042, 1'b1});

    // Random sweep, capturing every cycle
    for (int i = 0; i < 48; i++) begin
      logic [15:0] a, b;
      logic [2:0]  s;
      a = 16'($urandom);
      s = 3'($urandom_range(7));
      b = (s == 3'd5 || s == 3'd6) ? 16'($urandom_range(20)) :
          (i % 5 == 0) ? a : 16'($urandom);
      m = model(a, b, s);
      @(negedge clk); in_a = a; in_b = b; select = s; en = 1'b1; #1;
      chk("rnd_comb", alu_out, m[15:0]);
      @(posedge clk); #1;
      chk("rnd_reg", {res_q, flag_z, flag_c, flag_n, valid},
          {m[15:0], m[15:0] == 16'h0, m[16], m[15], 1'b1});
    end
    @(negedge clk); en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
